// File: rtl/uart_rx_sipo_if.sv
// Serial-line and parallel-byte bundle of the UART receiver.
// The receiver uses the slave modport; the line driver / byte consumer uses the master modport.
interface uart_rx_sipo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx_in;
    logic                 parity_odd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_error;
    logic                 frame_error;
    logic                 active_flag;
    logic                 done_flag;

    modport master (
        output rx_in, parity_odd,
        input  data_out, data_valid, parity_error, frame_error, active_flag, done_flag
    );

    modport slave (
        input  rx_in, parity_odd,
        output data_out, data_valid, parity_error, frame_error, active_flag, done_flag
    );
endinterface

// File: rtl/uart_rx_sipo.sv
// 16x-oversampled UART receiver: start, DATA_BITS LSB first, parity, stop -> byte plus error flags.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting around each bit centre.
module uart_rx_sipo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic           baud_clk,
    input logic           reset,
    uart_rx_sipo_if.slave uart
);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [TickW-1:0] DecTick = TickW'(OVERSAMPLE / 2);
`else
    localparam logic [TickW-1:0] DecTick = TickW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [TickW-1:0] TickMax = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q, rx_d_q;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 p_err_q, p_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 dv_q, dv_d;
    logic                 sample;
    logic                 at_dec;

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart.rx_in;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [TickW-1:0] VoteTickA = TickW'(OVERSAMPLE / 2 - 2);
    localparam logic [TickW-1:0] VoteTickB = TickW'(OVERSAMPLE / 2 - 1);

    // Early two votes are captured here; the third is the live rx_s at the decision tick.
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (tick_q == VoteTickA) vote_d[0] = rx_s_q;
        if (tick_q == VoteTickB) vote_d[1] = rx_s_q;
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) vote_q <= 2'b11;
        else       vote_q <= vote_d;
    end

    assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
    assign sample = rx_s_q;
`endif

    assign at_dec = (tick_q == DecTick);

    always_comb begin
        state_d    = state_q;
        tick_d     = (tick_q == TickMax) ? '0 : tick_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_err_d    = p_err_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        dv_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (rx_d_q && !rx_s_q) begin
                    state_d = StStart;
                    tick_d  = TickW'(1);
                end
            end
            StStart: begin
                if (at_dec) begin
                    if (sample) begin
                        state_d = StIdle;
                        tick_d  = '0;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (at_dec) begin
                    shift_d   = {sample, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == LastBit) state_d = StParity;
                end
            end
            StParity: begin
                if (at_dec) begin
                    p_err_d = ^shift_q ^ sample ^ uart.parity_odd;
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave mid-stop-bit so the next start edge is caught half a bit later.
                if (at_dec) begin
                    data_d     = shift_q;
                    perr_out_d = p_err_q;
                    ferr_out_d = ~sample;
                    dv_d       = 1'b1;
                    state_d    = StIdle;
                    tick_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_err_q    <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_err_q    <= p_err_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            dv_q       <= dv_d;
        end
    end

    assign uart.data_out     = data_q;
    assign uart.data_valid   = dv_q;
    assign uart.parity_error = perr_out_q;
    assign uart.frame_error  = ferr_out_q;
    assign uart.active_flag  = (state_q != StIdle);
    assign uart.done_flag    = (state_q == StIdle);
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed frames for uart_rx_sipo with a byte/flag scoreboard drained on each data_valid.
// Build with UART_RX_MAJORITY_VOTE_EN defined when the RTL is built that way (latency +1).
`timescale 1ns/1ps
module tb_uart_rx_sipo;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int Lat = 169;
`else
    localparam int Lat = 168;
`endif
    localparam int Os = 16;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic baud_clk = 1'b0;
    logic reset;
    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dv_count = 0;
    int   last_dv = -1;
    int   prev_dv = -1;
    int   act_rise = -1;
    int   act_fall = -1;
    logic act_prev = 1'b0;

    uart_rx_sipo_if #(.DATA_BITS(8)) uart ();

    uart_rx_sipo #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .baud_clk(baud_clk),
        .reset   (reset),
        .uart    (uart)
    );

    always #5 baud_clk = ~baud_clk;
    always @(posedge baud_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: records flag edges and drains the scoreboard on data_valid.
    always @(negedge baud_clk) begin
        if (uart.active_flag !== act_prev) begin
            if (uart.active_flag === 1'b1) act_rise = cyc;
            else                           act_fall = cyc;
        end
        act_prev = uart.active_flag;
        if (uart.data_valid === 1'b1) begin
            dv_count++;
            prev_dv = last_dv;
            last_dv = cyc;
            if (sb.size() == 0) begin
                check("unexpected_dv", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("data_out", 32'(uart.data_out), 32'(e_mon.data));
                check("parity_error", 32'(uart.parity_error), 32'(e_mon.perr));
                check("frame_error", 32'(uart.frame_error), 32'(e_mon.ferr));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Drives one bit per Os cycles; t0 is the first cycle the synchronised line is low.
    task automatic send_bits(input logic [10:0] frame, input int ncyc, output int t0);
        t0 = cyc + 2;
        for (int i = 0; i < ncyc; i++) begin
            uart.rx_in = frame[i/Os];
            tick(1);
        end
    endtask

    task automatic send_expect(input string tag, input logic [7:0] d, input logic par,
                               input logic stop, input logic perr, input logic ferr,
                               output int t0);
        int   n0;
        exp_t e;
        n0     = dv_count;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        sb.push_back(e);
        send_bits(mk(d, par, stop), 11 * Os, t0);
        check({tag, "_dv_count"}, 32'(dv_count), 32'(n0 + 1));
        check({tag, "_dv_cycle"}, 32'(last_dv), 32'(t0 + Lat));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, 32'(uart.data_out), 32'd0);
        check({tag, "_data_valid"}, 32'(uart.data_valid), 32'd0);
        check({tag, "_parity_error"}, 32'(uart.parity_error), 32'd0);
        check({tag, "_frame_error"}, 32'(uart.frame_error), 32'd0);
        check({tag, "_active_flag"}, 32'(uart.active_flag), 32'd0);
        check({tag, "_done_flag"}, 32'(uart.done_flag), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        int n0;
        int c;
        uart.rx_in      = 1'b1;
        uart.parity_odd = 1'b0;
        reset           = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(5);

        send_expect("a5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, t0);
        check("a5_active_rise", 32'(act_rise), 32'(t0 + 1));
        check("a5_active_fall", 32'(act_fall), 32'(t0 + Lat));
        tick(10);
        check("a5_done_flag", 32'(uart.done_flag), 32'd1);

        send_expect("3c_even", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, t0);
        tick(10);
        uart.parity_odd = 1'b1;
        send_expect("3c_odd", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, t0);
        uart.parity_odd = 1'b0;
        tick(10);

        // Stop bit low, then a held break: no restart until the line rises and falls again.
        send_expect("ff_break", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        n0 = dv_count;
        tick(20);
        check("break_done_flag", 32'(uart.done_flag), 32'd1);
        tick(20);
        uart.rx_in = 1'b1;
        tick(40);
        check("break_no_restart", 32'(dv_count), 32'(n0));
        send_expect("after_break", 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, t0);
        tick(10);

        n0         = dv_count;
        c          = cyc + 2;
        uart.rx_in = 1'b0;
        tick(4);
        uart.rx_in = 1'b1;
        tick(40);
        check("glitch4_started", 32'(act_rise), 32'(c + 1));
        check("glitch4_no_dv", 32'(dv_count), 32'(n0));
        check("glitch4_done_flag", 32'(uart.done_flag), 32'd1);

        uart.rx_in = 1'b0;
        tick(1);
        uart.rx_in = 1'b1;
        tick(40);
        check("glitch1_no_dv", 32'(dv_count), 32'(n0));
        check("glitch1_done_flag", 32'(uart.done_flag), 32'd1);

        send_expect("b2b_55", 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, t0);
        send_expect("b2b_81", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, t1);
        check("b2b_spacing", 32'(last_dv - prev_dv), 32'd176);
        tick(10);

        n0 = dv_count;
        send_bits(mk(8'h12, 1'b0, 1'b1), 82, t0);
        reset      = 1'b1;
        uart.rx_in = 1'b1;
        tick(2);
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick(30);
        check("midreset_no_dv", 32'(dv_count), 32'(n0));
        check("midreset_data_out", 32'(uart.data_out), 32'd0);
        check("midreset_done_flag", 32'(uart.done_flag), 32'd1);
        send_expect("12_after_reset", 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, t0);
        tick(10);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
